// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: 32-bit hits with no stall, 128-bit
// block refill over the memory busywait handshake, and a synchronous flush.
module instruction_cache #(
  parameter int NUM_SETS = 8,
  parameter int IDX      = $clog2(NUM_SETS),
  parameter int TAG_W    = 32 - 4 - IDX
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          read,
  input  logic [31:0]   address,
  input  logic          flush,
  output logic [31:0]   instruction,
  output logic          busywait,
  output logic          mem_read,
  output logic [27:0]   mem_address,
  input  logic [127:0]  mem_readdata,
  input  logic          mem_busywait
);

  typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_t;

  state_t                r_state;
  logic                  r_mem_read;
  logic [NUM_SETS-1:0]   r_valid;
  logic [TAG_W-1:0]      r_tag  [NUM_SETS];
  logic [127:0]          r_data [NUM_SETS];

  logic [1:0]            w_offset;
  logic [IDX-1:0]        w_index;
  logic [TAG_W-1:0]      w_tag;
  logic [127:0]          w_line;
  logic                  w_hit;
  logic                  w_unused;

  assign w_offset    = address[3:2];
  assign w_index     = address[4+IDX-1:4];
  assign w_tag       = address[31:4+IDX];
  assign w_unused    = ^address[1:0];

  assign w_line      = r_data[w_index];
  assign w_hit       = read & r_valid[w_index] & (r_tag[w_index] == w_tag);
  assign instruction = w_line[32*w_offset +: 32];

  // Outside IDLE the CPU is always stalled; in IDLE only a miss stalls it.
  assign busywait    = (r_state != S_IDLE) | (read & ~w_hit);
  assign mem_read    = r_mem_read;
  assign mem_address = address[31:4];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mem_read <= 1'b0;
      r_valid    <= '0;
    end else begin
      // Flush first so an UPDATE on the same edge re-validates its own line.
      if (flush) r_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (read && !w_hit) begin
            r_state    <= S_MEM_READ;
            r_mem_read <= 1'b1;
          end
        end
        S_MEM_READ: begin
          if (!mem_busywait) begin
            r_state    <= S_UPDATE;
            r_mem_read <= 1'b0;
          end
        end
        S_UPDATE: begin
          r_valid[w_index] <= 1'b1;
          r_state          <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_mem_read <= 1'b0;
        end
      endcase
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone gate their use.
  always_ff @(posedge clock) begin
    if (!reset && r_state == S_UPDATE) begin
      r_data[w_index] <= mem_readdata;
      r_tag[w_index]  <= w_tag;
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Bench for instruction_cache: directed vector table, multi-cycle corner
// sequences, and random fetches against a block-level cache model.
module tb_instruction_cache;

  logic          clock = 1'b0;
  logic          reset;
  logic          read;
  logic [31:0]   address;
  logic          flush;
  logic [31:0]   instruction;
  logic          busywait;
  logic          mem_read;
  logic [27:0]   mem_address;
  logic [127:0]  mem_readdata;
  logic          mem_busywait;

  instruction_cache dut (
    .clock(clock), .reset(reset), .read(read), .address(address),
    .flush(flush), .instruction(instruction), .busywait(busywait),
    .mem_read(mem_read), .mem_address(mem_address),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int mem_n = 15;   // number of mem_read cycles per refill (last one has busywait low)
  int mcnt  = 0;
  int addr_err;

  // Model: which block address each index holds, if any.
  bit          m_valid [8];
  logic [27:0] m_ba    [8];

  function automatic logic [127:0] blk(input logic [27:0] ba);
    logic [127:0] r;
    if (ba == 28'd0) return 128'h001001b3_03210113_00208093_3e800013;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = {4'hA, ba} ^ (32'h9E3779B1 * (k + 1));
    return r;
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [127:0] b;
    b = blk(a[31:4]);
    return b[32*a[3:2] +: 32];
  endfunction

  function automatic bit model_miss(input logic [31:0] a);
    logic [27:0] ba;
    ba = a[31:4];
    return !(m_valid[ba % 8] && m_ba[ba % 8] == ba);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Memory: busywait high for the first mem_n-1 mem_read cycles, low on the last,
  // block data appears with that last cycle and stays until the next request.
  initial begin
    mem_busywait = 1'b1;
    mem_readdata = '0;
    forever begin
      @(posedge clock); #1;
      if (mem_read) begin
        mcnt++;
        mem_busywait = (mcnt < mem_n);
        mem_readdata = (mcnt >= mem_n) ? blk(mem_address) : {4{32'hDEADBEEF}};
      end else begin
        mcnt = 0;
        mem_busywait = 1'b1;
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input bit fl_upd,
                       output logic [31:0] ins, output int stall, output int mrd);
    bit done, seen;
    done = 0; seen = 0; stall = 0; mrd = 0; ins = 'x; addr_err = 0;
    read = 1'b1; address = a;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clock);
      if (mem_read) begin
        mrd++; seen = 1;
        if (mem_address !== a[31:4]) addr_err++;
      end
      if (!busywait) begin
        ins = instruction; done = 1;
      end else begin
        stall++;
        if (fl_upd && seen && !mem_read) flush = 1'b1;   // UPDATE cycle
      end
      @(posedge clock); #1;
      flush = 1'b0;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL fetch_timeout: addr %h never returned, expected completion", a);
    end
  endtask

  task automatic run(input string nm, input logic [31:0] a, input logic [31:0] exp_ins,
                     input bit exp_miss, input bit fl_upd);
    logic [31:0] ins;
    int stall, mrd;
    fetch(a, fl_upd, ins, stall, mrd);
    chk({nm, " instr"}, ins, exp_ins);
    chk({nm, " stall"}, stall, exp_miss ? mem_n + 2 : 0);
    chk({nm, " mem_read cycles"}, mrd, exp_miss ? mem_n : 0);
    chk({nm, " mem_address"}, addr_err, 0);
    if (fl_upd) model_clear();
    if (exp_miss) begin
      m_valid[a[6:4]] = 1'b1;
      m_ba[a[6:4]]    = a[31:4];
    end
  endtask

  task automatic flush_pulse();
    read = 1'b0; flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    model_clear();
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ins;
    bit          miss;
  } vec_t;

  vec_t tv[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mrd;
    logic [31:0] a;
    bit m;

    tv[0] = '{32'h0000_0000, 32'h3e800013, 1'b1};
    tv[1] = '{32'h0000_0004, 32'h00208093, 1'b0};
    tv[2] = '{32'h0000_0008, 32'h03210113, 1'b0};
    tv[3] = '{32'h0000_000C, 32'h001001b3, 1'b0};
    tv[4] = '{32'h0000_0080, word_of(32'h80), 1'b1};
    tv[5] = '{32'h0000_0000, 32'h3e800013, 1'b1};
    tv[6] = '{32'h0000_001E, word_of(32'h1C), 1'b1};
    tv[7] = '{32'h0000_0014, word_of(32'h14), 1'b0};

    reset = 1'b1; read = 1'b0; address = '0; flush = 1'b0;
    model_clear();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset busywait", busywait, 0);
    chk("reset mem_read", mem_read, 0);
    @(posedge clock); #1;

    mem_n = 15;
    for (int i = 0; i < 8; i++) run($sformatf("vec%0d", i), tv[i].addr, tv[i].ins, tv[i].miss, 1'b0);

    // Flush pulse after a warm line drops it.
    read = 1'b0; @(posedge clock); #1;
    flush_pulse();
    run("post-flush 0x0", 32'h0, 32'h3e800013, 1'b1, 1'b0);

    // Flush on the UPDATE edge: the refilled line survives, others do not.
    mem_n = 4;
    run("flush@update 0x24", 32'h24, word_of(32'h24), 1'b1, 1'b1);
    run("refetch 0x24", 32'h24, word_of(32'h24), 1'b0, 1'b0);
    run("flushed 0x0", 32'h0, 32'h3e800013, 1'b1, 1'b0);

    // Reset asserted in the 5th mem_read cycle of a refill.
    mem_n = 15;
    read = 1'b1; address = 32'h40; mrd = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (mem_read) mrd++;
      if (mrd == 5) break;
      @(posedge clock); #1;
    end
    chk("mem_read cycles before reset", mrd, 5);
    reset = 1'b1; read = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    chk("mid-refill reset mem_read", mem_read, 0);
    chk("mid-refill reset busywait", busywait, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    model_clear();
    run("refetch after reset 0x40", 32'h40, word_of(32'h40), 1'b1, 1'b0);

    // Random fetches over a small address pool so hits, conflicts and flushes mix.
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 9) == 0) flush_pulse();
      if ($urandom_range(0, 4) == 0) begin
        read = 1'b0; @(posedge clock); #1;
      end
      mem_n = $urandom_range(1, 5);
      a = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) |
          ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      m = model_miss(a);
      run($sformatf("rand%0d", it), a, word_of(a), m, m && ($urandom_range(0, 5) == 0));
    end

    read = 1'b0;
    @(posedge clock); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
